mult_result_buffer: RTL and testbench
=====================================

# mult_result_buffer

Result-side companion to the pipelined multiplier. It captures every valid product leaving the final multiplier stage, which cannot stall, into a small circular FIFO. It then presents the oldest surviving result to the common data bus (CDB) arbiter with a request/grant handshake. While results wait, it applies branch-recovery squashing and branch-mask clearing, and it throttles multiplier issue so that in-flight products can never overflow the buffer.

## Interface
- DEPTH, 8: number of FIFO entries; power of two; must exceed PIPE_DEPTH.
- PIPE_DEPTH, 4: multiplier stages in flight; sets the issue throttle threshold.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; the block resets when reset==0 at posedge.
- inst_valid_in  in  1  valid product from the final multiplier stage.
- product_in  in  64  product value.
- dest_reg_in  in  6  destination physical register.
- NPC_in  in  64  next PC of the multiply instruction.
- bmask_in  in  4  branch dependency mask.
- br_rec_en_1, br_rec_en_2  in  1  branch resolution events.
- br_marker_1, br_marker_2  in  3  bmask bit index for each resolving branch.
- br_mispre_1, br_mispre_2  in  1  the resolving branch was mispredicted.
- cdb_grant  in  1  arbiter accepts the current request.
- cdb_req  out  1  head result is valid and requesting the CDB.
- cdb_value  out  64  head product.
- cdb_dest_reg  out  6  head destination register.
- cdb_NPC  out  64  head NPC.
- cdb_bmask  out  4  head bmask, with this cycle's resolved bits already cleared.
- issue_stall  out  1  multiplier issue must hold.
- overflow_err  out  1  sticky; a push arrived while the FIFO was full.

## Operation
- Storage: DEPTH entries, each holding {valid, product, dest_reg, NPC, bmask}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- Hit definition: an entry or an incoming result is hit when (br_rec_en_k & br_mispre_k & bmask[br_marker_k]) for k = 1 or 2. A hit clears valid.
- Mask clearing: br_rec_en_k clears bit br_marker_k in every stored bmask, and in the bmask written by a push in the same cycle. This happens whether the branch was mispredicted or not.
- Push: inst_valid_in=1 and not hit, and not bypassed, writes the entry at tail, then tail+1 and count+1.
- A hit incoming result is dropped and not written.
- inst_valid_in=0 means no push.
- Push while count==DEPTH: the result is dropped and overflow_err is set. overflow_err clears only on reset.
- Pop on grant: cdb_req & cdb_grant advances head and decrements count.
- Squash drain: when the head entry has valid==0 and count>0, head advances and count decrements, with no request made. At most one pop of either kind per cycle.
- cdb_req = head.valid & count>0 & ~(head hit this cycle).
- cdb_bmask = head.bmask with this cycle's br_rec_en bits cleared.
- cdb_* data outputs hold the head entry. When cdb_req=0 they hold don't-care values.
- Push and pop in the same cycle are allowed at any count, including full: count is unchanged and the pointers both advance.
- issue_stall = (count >= DEPTH - PIPE_DEPTH). This leaves room for PIPE_DEPTH in-flight products.

## Timing
- Latency: a result arriving at cycle N raises cdb_req in cycle N+1 when the FIFO held no older valid entry.
- cdb_req is combinational from the stored state and the branch inputs. It has no path from cdb_grant.
- Squash takes effect in the same cycle: an entry hit at cycle N is never granted at N or later.
- A squashed head costs one drain cycle. K consecutive squashed entries cost K cycles.
- Reset (reset==0 at posedge): count=0, head=tail=0, all valid bits cleared, overflow_err=0. Resulting outputs: cdb_req=0, issue_stall=0, cdb_value=0, cdb_NPC=0, cdb_bmask=0, cdb_dest_reg=`ZERO_REG.
- Reset mid-operation discards all entries, including one being granted that cycle.

## Configuration
- MULT_RESULT_BYPASS_EN defined: when count==0 and the incoming result is valid and not hit, the result drives cdb_* and cdb_req in the same cycle. If cdb_grant=1 it is not written; otherwise it is pushed normally.
- MULT_RESULT_BYPASS_EN undefined: all results pass through the FIFO, with a minimum latency of one cycle.

## Test plan
- Reset then a single push: a product of 0x0000_0000_0000_0006 to dest 5 at cycle 1, with cdb_grant tied 1. Required response: cdb_req=1 with value 6 and dest 5 at cycle 2, then cdb_req=0 at cycle 3. With the bypass macro defined, cdb_req=1 at cycle 1 instead.
- Fill with cdb_grant=0: pushing 4 entries raises issue_stall (count 4 >= 8-4). Pushing 8 entries reaches full. A 9th push sets overflow_err=1 and the head stays entry 0.
- Mispredict squash: stored entries with bmask 0001, 0010 and 0001 at head, 1 and 2 respectively. Asserting br_rec_en_1=1, br_marker_1=0, br_mispre_1=1 must deassert cdb_req the same cycle. Head drains, then the 0010 entry requests; the third entry is never requested.
- Correct prediction: br_rec_en_2=1, br_marker_2=1, br_mispre_2=0 against a head with bmask 0011. Same-cycle cdb_bmask=0001, and the stored bmask reads 0001 afterward.
- Simultaneous push, grant and branch events at count==DEPTH: count stays 8 and overflow_err stays 0. An incoming result hit by br_mispre_1 is not stored and count drops to 7.
- Reset asserted (reset=0) with 5 valid entries: on the next cycle cdb_req=0, issue_stall=0 and cdb_dest_reg=`ZERO_REG.

Source files
------------

// File: rtl/mult_result_buffer_if.sv
// CDB handshake bundle between the multiply result buffer (master) and the
// common data bus arbiter (slave).
interface mult_result_buffer_if;
  logic        cdb_req;
  logic        cdb_grant;
  logic [63:0] cdb_value;
  logic [5:0]  cdb_dest_reg;
  logic [63:0] cdb_NPC;
  logic [3:0]  cdb_bmask;

  modport master (
    output cdb_req,
    output cdb_value,
    output cdb_dest_reg,
    output cdb_NPC,
    output cdb_bmask,
    input  cdb_grant
  );

  modport slave (
    input  cdb_req,
    input  cdb_value,
    input  cdb_dest_reg,
    input  cdb_NPC,
    input  cdb_bmask,
    output cdb_grant
  );
endinterface

// File: rtl/mult_result_buffer.sv
// mult_result_buffer: circular FIFO behind the non-stalling final multiplier
// stage. It captures products, presents the oldest live one to the CDB
// arbiter, applies branch squash/mask clearing while results wait, and
// throttles multiplier issue so in-flight products always fit.
// Optional feature: define MULT_RESULT_BYPASS_EN to let a result arriving at
// an empty buffer request the CDB in its arrival cycle.
`ifndef ZERO_REG
`define ZERO_REG 6'd0
`endif

module mult_result_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PIPE_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inst_valid_in,
  input  logic [63:0]          product_in,
  input  logic [5:0]           dest_reg_in,
  input  logic [63:0]          NPC_in,
  input  logic [3:0]           bmask_in,
  input  logic                 br_rec_en_1,
  input  logic                 br_rec_en_2,
  input  logic [2:0]           br_marker_1,
  input  logic [2:0]           br_marker_2,
  input  logic                 br_mispre_1,
  input  logic                 br_mispre_2,
  mult_result_buffer_if.master cdb,
  output logic                 issue_stall,
  output logic                 overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [63:0]      product_q [DEPTH];
  logic [5:0]       dest_q    [DEPTH];
  logic [63:0]      npc_q     [DEPTH];
  logic [3:0]       bmask_q   [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [3:0]       clr_sel;   // bmask bits resolved this cycle
  logic [3:0]       mis_sel;   // bmask bits resolved as mispredicted this cycle
  logic [DEPTH-1:0] ent_hit;
  logic [DEPTH-1:0] valid_nxt;
  logic             nonempty, full, head_valid, head_hit, fifo_req;
  logic             in_ok, byp_act, pop, push_req, push, ovf_set;

  // Decode the two branch resolution ports into per-bit clear/squash selects
  always_comb begin
    clr_sel = '0;
    mis_sel = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (br_rec_en_1 && br_marker_1 == 3'(b)) begin
        clr_sel[b] = 1'b1;
        if (br_mispre_1) mis_sel[b] = 1'b1;
      end
      if (br_rec_en_2 && br_marker_2 == 3'(b)) begin
        clr_sel[b] = 1'b1;
        if (br_mispre_2) mis_sel[b] = 1'b1;
      end
    end
  end

  // Per-entry squash detection against the stored (pre-clear) masks
  always_comb begin
    ent_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_hit[i] = |(bmask_q[i] & mis_sel);
    end
  end

  // Head status, pop/push decisions and next valid vector
  always_comb begin
    nonempty   = (count_q != '0);
    full       = (count_q == CNT_W'(DEPTH));
    head_valid = valid_q[head_q];
    head_hit   = |(bmask_q[head_q] & mis_sel);
    fifo_req   = head_valid & nonempty & ~head_hit;
    in_ok      = inst_valid_in & ~(|(bmask_in & mis_sel));
`ifdef MULT_RESULT_BYPASS_EN
    byp_act    = in_ok & ~nonempty;
`else
    byp_act    = 1'b0;
`endif
    // A granted request pops; a stale (squashed) head drains without request.
    // The two are mutually exclusive because they need opposite head_valid.
    pop        = (fifo_req & cdb.cdb_grant) | (~head_valid & nonempty);
    push_req   = in_ok & ~(byp_act & cdb.cdb_grant);
    push       = push_req & (~full | pop);
    ovf_set    = push_req & full & ~pop;

    valid_nxt  = valid_q & ~ent_hit;
    if (push) valid_nxt[tail_q] = 1'b1;
  end

  // CDB presentation: head entry, bypassed input, or a clean idle pattern
  always_comb begin
    cdb.cdb_req      = fifo_req;
    cdb.cdb_value    = product_q[head_q];
    cdb.cdb_dest_reg = dest_q[head_q];
    cdb.cdb_NPC      = npc_q[head_q];
    cdb.cdb_bmask    = bmask_q[head_q] & ~clr_sel;
    if (!nonempty) begin
      cdb.cdb_value    = '0;
      cdb.cdb_dest_reg = `ZERO_REG;
      cdb.cdb_NPC      = '0;
      cdb.cdb_bmask    = '0;
    end
    if (byp_act) begin
      cdb.cdb_req      = 1'b1;
      cdb.cdb_value    = product_in;
      cdb.cdb_dest_reg = dest_reg_in;
      cdb.cdb_NPC      = NPC_in;
      cdb.cdb_bmask    = bmask_in & ~clr_sel;
    end
  end

  assign issue_stall = (count_q >= CNT_W'(DEPTH - PIPE_DEPTH));

  // Payload storage; liveness is tracked by valid_q so no reset is needed here
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bmask_q[i] <= bmask_q[i] & ~clr_sel;
    end
    if (push) begin
      product_q[tail_q] <= product_in;
      dest_q[tail_q]    <= dest_reg_in;
      npc_q[tail_q]     <= NPC_in;
      bmask_q[tail_q]   <= bmask_in & ~clr_sel;
    end
  end

  // Pointers, occupancy, valid bits and the sticky overflow flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      overflow_err <= 1'b0;
    end else begin
      valid_q <= valid_nxt;
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (ovf_set) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_result_buffer.sv
// Self-checking bench for mult_result_buffer: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
`ifndef ZERO_REG
`define ZERO_REG 6'd0
`endif

module tb_mult_result_buffer;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned PIPE_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid_in = 1'b0;
  logic [63:0] product_in = '0;
  logic [5:0]  dest_reg_in = '0;
  logic [63:0] NPC_in = '0;
  logic [3:0]  bmask_in = '0;
  logic        br_rec_en_1 = 1'b0, br_rec_en_2 = 1'b0;
  logic [2:0]  br_marker_1 = '0, br_marker_2 = '0;
  logic        br_mispre_1 = 1'b0, br_mispre_2 = 1'b0;
  logic        issue_stall, overflow_err;

  mult_result_buffer_if cdb();

  mult_result_buffer #(.DEPTH(DEPTH), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .inst_valid_in(inst_valid_in),
    .product_in   (product_in),
    .dest_reg_in  (dest_reg_in),
    .NPC_in       (NPC_in),
    .bmask_in     (bmask_in),
    .br_rec_en_1  (br_rec_en_1),
    .br_rec_en_2  (br_rec_en_2),
    .br_marker_1  (br_marker_1),
    .br_marker_2  (br_marker_2),
    .br_mispre_1  (br_mispre_1),
    .br_mispre_2  (br_mispre_2),
    .cdb          (cdb),
    .issue_stall  (issue_stall),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [63:0] prod;
    logic [5:0]  dest;
    logic [63:0] npc;
    logic [3:0]  bm;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic        last_req, last_stall, last_ovf;
  logic [63:0] last_value, last_npc;
  logic [5:0]  last_dest;
  logic [3:0]  last_bmask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [3:0] bm);
    logic h;
    h = 1'b0;
    if (br_rec_en_1 && br_mispre_1 && br_marker_1 < 3'd4 && bm[br_marker_1[1:0]]) h = 1'b1;
    if (br_rec_en_2 && br_mispre_2 && br_marker_2 < 3'd4 && bm[br_marker_2[1:0]]) h = 1'b1;
    return h;
  endfunction

  function automatic logic [3:0] m_clr(input logic [3:0] bm);
    logic [3:0] r;
    r = bm;
    if (br_rec_en_1 && br_marker_1 < 3'd4) r[br_marker_1[1:0]] = 1'b0;
    if (br_rec_en_2 && br_marker_2 < 3'd4) r[br_marker_2[1:0]] = 1'b0;
    return r;
  endfunction

  // One clock cycle: inputs already driven; check at negedge, advance model,
  // then return 1 time unit after the next posedge.
  task automatic step();
    logic e_req, byp, pop, push_req;
    ent_t h, t;
    @(negedge clock);
    e_req = 1'b0;
    byp   = 1'b0;
    h     = '{1'b0, 64'd0, 6'd0, 64'd0, 4'd0};
    if (q.size() == 0) begin
`ifdef MULT_RESULT_BYPASS_EN
      if (inst_valid_in && !m_hit(bmask_in)) begin
        byp   = 1'b1;
        e_req = 1'b1;
        h     = '{1'b1, product_in, dest_reg_in, NPC_in, bmask_in};
      end
`endif
    end else begin
      h     = q[0];
      e_req = h.valid && !m_hit(h.bm);
    end

    last_req   = cdb.cdb_req;
    last_value = cdb.cdb_value;
    last_dest  = cdb.cdb_dest_reg;
    last_npc   = cdb.cdb_NPC;
    last_bmask = cdb.cdb_bmask;
    last_stall = issue_stall;
    last_ovf   = overflow_err;

    check("cdb_req", {63'd0, last_req}, {63'd0, e_req});
    check("issue_stall", {63'd0, last_stall}, {63'd0, (q.size() >= DEPTH - PIPE_DEPTH)});
    check("overflow_err", {63'd0, last_ovf}, {63'd0, m_ovf});
    if (e_req) begin
      check("cdb_value", last_value, h.prod);
      check("cdb_dest_reg", {58'd0, last_dest}, {58'd0, h.dest});
      check("cdb_NPC", last_npc, h.npc);
      check("cdb_bmask", {60'd0, last_bmask}, {60'd0, m_clr(h.bm)});
    end

    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (q.size() > 0) && ((e_req && !byp && cdb.cdb_grant) || !q[0].valid);
      foreach (q[i]) begin
        t = q[i];
        if (m_hit(t.bm)) t.valid = 1'b0;
        t.bm = m_clr(t.bm);
        q[i] = t;
      end
      if (pop) void'(q.pop_front());
      push_req = inst_valid_in && !m_hit(bmask_in) && !(byp && cdb.cdb_grant);
      if (push_req) begin
        if (q.size() < DEPTH)
          q.push_back('{1'b1, product_in, dest_reg_in, NPC_in, m_clr(bmask_in)});
        else
          m_ovf = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    inst_valid_in = 1'b0;
    br_rec_en_1 = 1'b0; br_rec_en_2 = 1'b0;
    br_mispre_1 = 1'b0; br_mispre_2 = 1'b0;
    br_marker_1 = '0;   br_marker_2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic cyc_push(input logic [63:0] p, input logic [5:0] d, input logic [3:0] bm);
    inst_valid_in = 1'b1;
    product_in    = p;
    dest_reg_in   = d;
    NPC_in        = p + 64'd4;
    bmask_in      = bm;
    step();
    inst_valid_in = 1'b0;
  endtask

  initial begin
    // Bring the DUT out of its unknown power-up state before checking starts
    reset = 1'b0;
    cdb.cdb_grant = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    step();

    // Single push with grant tied high
    do_reset();
    cdb.cdb_grant = 1'b1;
    cyc_push(64'd6, 6'd5, 4'b0000);
`ifdef MULT_RESULT_BYPASS_EN
    check("t1_bypass_req", {63'd0, last_req}, 64'd1);
    check("t1_bypass_val", last_value, 64'd6);
    step();
    check("t1_after_req", {63'd0, last_req}, 64'd0);
`else
    check("t1_arrival_req", {63'd0, last_req}, 64'd0);
    step();
    check("t1_req", {63'd0, last_req}, 64'd1);
    check("t1_value", last_value, 64'd6);
    check("t1_dest", {58'd0, last_dest}, 64'd5);
    step();
    check("t1_req_done", {63'd0, last_req}, 64'd0);
`endif

    // Fill to full with grant held low, then overflow
    do_reset();
    cdb.cdb_grant = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc_push(64'h100 + 64'(i), 6'(i + 1), 4'b0000);
      if (i == 3) check("fill_stall_cnt3", {63'd0, last_stall}, 64'd0);
      if (i == 4) check("fill_stall_cnt4", {63'd0, last_stall}, 64'd1);
    end
    step();
    check("fill_ovf", {63'd0, last_ovf}, 64'd1);
    check("fill_head", last_value, 64'h100);

    // Mispredict squash of the head
    do_reset();
    cdb.cdb_grant = 1'b0;
    cyc_push(64'd100, 6'd1, 4'b0001);
    cyc_push(64'd200, 6'd2, 4'b0010);
    cyc_push(64'd300, 6'd3, 4'b0001);
    step();
    check("sq_head_req", {63'd0, last_req}, 64'd1);
    br_rec_en_1 = 1'b1; br_marker_1 = 3'd0; br_mispre_1 = 1'b1;
    step();
    check("sq_same_cycle", {63'd0, last_req}, 64'd0);
    idle_inputs();
    cdb.cdb_grant = 1'b1;
    step();
    check("sq_drain", {63'd0, last_req}, 64'd0);
    step();
    check("sq_second_req", {63'd0, last_req}, 64'd1);
    check("sq_second_val", last_value, 64'd200);
    step();
    check("sq_third_none", {63'd0, last_req}, 64'd0);
    step();
    check("sq_empty", {63'd0, last_req}, 64'd0);

    // Correct prediction clears a mask bit
    do_reset();
    cdb.cdb_grant = 1'b0;
    cyc_push(64'd77, 6'd9, 4'b0011);
    br_rec_en_2 = 1'b1; br_marker_2 = 3'd1; br_mispre_2 = 1'b0;
    step();
    check("cp_bmask_now", {60'd0, last_bmask}, 64'd1);
    check("cp_req_now", {63'd0, last_req}, 64'd1);
    idle_inputs();
    step();
    check("cp_bmask_after", {60'd0, last_bmask}, 64'd1);

    // Push + grant + branch activity while full
    do_reset();
    cdb.cdb_grant = 1'b0;
    for (int i = 0; i < 8; i++) cyc_push(64'h200 + 64'(i), 6'(i), 4'b0000);
    cdb.cdb_grant = 1'b1;
    br_rec_en_1 = 1'b1; br_marker_1 = 3'd2; br_mispre_1 = 1'b0;
    cyc_push(64'h2AA, 6'd20, 4'b0100);
    br_rec_en_1 = 1'b1; br_marker_1 = 3'd0; br_mispre_1 = 1'b1;
    cyc_push(64'h2BB, 6'd21, 4'b0001);
    idle_inputs();
    cdb.cdb_grant = 1'b0;
    step();
    check("full_ovf_clear", {63'd0, last_ovf}, 64'd0);
    cyc_push(64'h2CC, 6'd22, 4'b0000);
    step();
    check("full_refill_ovf", {63'd0, last_ovf}, 64'd0);
    cyc_push(64'h2DD, 6'd23, 4'b0000);
    step();
    check("full_then_ovf", {63'd0, last_ovf}, 64'd1);

    // Reset with 5 live entries while one is being granted
    do_reset();
    cdb.cdb_grant = 1'b0;
    for (int i = 0; i < 5; i++) cyc_push(64'h300 + 64'(i), 6'(i + 7), 4'b0000);
    cdb.cdb_grant = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    cdb.cdb_grant = 1'b0;
    step();
    check("rst_req", {63'd0, last_req}, 64'd0);
    check("rst_stall", {63'd0, last_stall}, 64'd0);
    check("rst_dest", {58'd0, last_dest}, {58'd0, `ZERO_REG});
    check("rst_value", last_value, 64'd0);
    check("rst_npc", last_npc, 64'd0);
    check("rst_bmask", {60'd0, last_bmask}, 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) != 0);
      inst_valid_in = ($urandom_range(0, 9) < 6);
      product_in    = {$urandom, $urandom};
      dest_reg_in   = 6'($urandom);
      NPC_in        = {$urandom, $urandom};
      bmask_in      = 4'($urandom);
      br_rec_en_1   = ($urandom_range(0, 99) < 15);
      br_rec_en_2   = ($urandom_range(0, 99) < 15);
      br_marker_1   = 3'($urandom_range(0, 3));
      br_marker_2   = 3'($urandom_range(0, 3));
      br_mispre_1   = ($urandom_range(0, 9) < 3);
      br_mispre_2   = ($urandom_range(0, 9) < 3);
      cdb.cdb_grant = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
